// File: rtl/vga_capture.sv
// vga_capture: 640x480 VGA timing tracker and frame capture.
// Tracks hsync/vsync against fixed 800x525 timing, locks after one clean frame
// and emits one write per visible pixel while locked.
// Optional per-frame CRC-8 of the written pixels: define VGA_CAPTURE_CRC_EN.
module vga_capture (
    input  logic        clk,
    input  logic        reset_,
    input  logic        i_h_sync,
    input  logic        i_v_sync,
    input  logic        i_r,
    input  logic        i_g,
    input  logic        i_b,
    output logic        o_wr_en,
    output logic [18:0] o_wr_addr,
    output logic [2:0]  o_wr_data,
    output logic        o_locked,
    output logic        o_frame_start,
    output logic        o_frame_done,
    output logic        o_sync_err,
    output logic [7:0]  o_frame_crc,
    output logic        o_crc_valid
);
    localparam logic [9:0] H_LAST      = 10'd799;
    localparam logic [9:0] V_LAST      = 10'd524;
    localparam logic [9:0] H_VIS_FIRST = 10'd144;  // sync 96 + back porch 48
    localparam logic [9:0] H_VIS_LAST  = 10'd783;
    localparam logic [9:0] V_VIS_FIRST = 10'd35;   // sync 2 + back porch 33
    localparam logic [9:0] V_VIS_LAST  = 10'd514;
    localparam logic [9:0] CNT_MAX     = 10'd1023;
    localparam logic [9:0] CNT_PRE_MAX = 10'd1022;

    typedef enum logic [1:0] {SEARCH, SYNCED, LOCKED} state_t;

    // input stage and one-deep edge history
    logic       r_hs, r_hs_d, r_vs, r_vs_d;
    logic [2:0] r_rgb;
    // counter / state stage
    logic [9:0] r_h_cnt, r_v_cnt;
    logic [2:0] r_rgb_d;
    logic       r_skip;
    state_t     r_state;

    logic       w_hs_fall, w_vs_fall;
    logic       w_line_err, w_frame_err;
    logic [9:0] w_h_next, w_v_next;
    logic       w_wr, w_last;
    logic [9:0] w_pix;
    logic [8:0] w_line;

    assign w_hs_fall = r_hs_d & ~r_hs;
    assign w_vs_fall = r_vs_d & ~r_vs;

    // Counter values for the pixel currently in the input stage.
    assign w_h_next = w_hs_fall ? 10'd0 :
                      (r_h_cnt == CNT_MAX) ? CNT_MAX : r_h_cnt + 10'd1;
    assign w_v_next = w_vs_fall ? 10'd0 :
                      !w_hs_fall ? r_v_cnt :
                      (r_v_cnt == CNT_MAX) ? CNT_MAX : r_v_cnt + 10'd1;

    // Errors compare against the count of the previous pixel/line; r_skip
    // exempts the first line edge after SYNCED is entered (it may be partial).
    assign w_line_err  = (w_hs_fall && (r_h_cnt != H_LAST) && !r_skip) ||
                         (!w_hs_fall && (r_h_cnt == CNT_PRE_MAX));
    assign w_frame_err = (w_vs_fall && (r_v_cnt != V_LAST)) ||
                         (!w_vs_fall && w_hs_fall && (r_v_cnt == CNT_PRE_MAX));

    // Visible-window decode on the counter stage; line fits 9 bits in-window,
    // so modulo-512 subtraction yields the exact line number.
    assign w_wr   = (r_state == LOCKED) &&
                    (r_h_cnt >= H_VIS_FIRST) && (r_h_cnt <= H_VIS_LAST) &&
                    (r_v_cnt >= V_VIS_FIRST) && (r_v_cnt <= V_VIS_LAST);
    assign w_last = (r_h_cnt == H_VIS_LAST) && (r_v_cnt == V_VIS_LAST);
    assign w_pix  = r_h_cnt - H_VIS_FIRST;
    assign w_line = r_v_cnt[8:0] - V_VIS_FIRST[8:0];

    // Register sync/colour inputs and keep the previous sync sample for edges
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_hs   <= 1'b1;
            r_hs_d <= 1'b1;
            r_vs   <= 1'b1;
            r_vs_d <= 1'b1;
            r_rgb  <= 3'b000;
        end else begin
            r_hs   <= i_h_sync;
            r_hs_d <= r_hs;
            r_vs   <= i_v_sync;
            r_vs_d <= r_vs;
            r_rgb  <= {i_r, i_g, i_b};
        end
    end

    // Counters and lock state machine with registered status outputs
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_h_cnt       <= 10'd0;
            r_v_cnt       <= 10'd0;
            r_rgb_d       <= 3'b000;
            r_skip        <= 1'b0;
            r_state       <= SEARCH;
            o_locked      <= 1'b0;
            o_sync_err    <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            r_h_cnt       <= w_h_next;
            r_v_cnt       <= w_v_next;
            r_rgb_d       <= r_rgb;
            o_sync_err    <= 1'b0;
            o_frame_start <= 1'b0;
            if (w_hs_fall)
                r_skip <= 1'b0;
            case (r_state)
                SEARCH: begin
                    if (w_vs_fall) begin
                        r_state <= SYNCED;
                        r_skip  <= 1'b1;
                    end
                end
                default: begin
                    if (w_line_err || w_frame_err) begin
                        o_sync_err <= 1'b1;
                        o_locked   <= 1'b0;
                        if (w_vs_fall) begin
                            r_state <= SYNCED;
                            r_skip  <= 1'b1;
                        end else begin
                            r_state <= SEARCH;
                        end
                    end else if (w_vs_fall) begin
                        r_state       <= LOCKED;
                        o_locked      <= 1'b1;
                        o_frame_start <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Write port: strobe every cycle, address/data only move on a write
    always_ff @(posedge clk) begin
        if (!reset_) begin
            o_wr_en      <= 1'b0;
            o_wr_addr    <= 19'd0;
            o_wr_data    <= 3'b000;
            o_frame_done <= 1'b0;
        end else begin
            o_wr_en      <= w_wr;
            o_frame_done <= w_wr && w_last;
            if (w_wr) begin
                o_wr_addr <= {w_line, w_pix};
                o_wr_data <= r_rgb_d;
            end
        end
    end

`ifdef VGA_CAPTURE_CRC_EN
    logic [7:0] r_crc;

    function automatic logic [7:0] f_crc8(input logic [7:0] c, input logic [2:0] d);
        logic [7:0] x;
        x = c ^ {5'b00000, d};
        for (int i = 0; i < 8; i++)
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    // Running CRC over written pixels, restarted at each vsync edge
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_crc       <= 8'h00;
            o_frame_crc <= 8'h00;
            o_crc_valid <= 1'b0;
        end else begin
            o_crc_valid <= 1'b0;
            if (w_vs_fall)
                r_crc <= 8'h00;
            else if (w_wr)
                r_crc <= f_crc8(r_crc, r_rgb_d);
            if (w_wr && w_last) begin
                o_frame_crc <= f_crc8(r_crc, r_rgb_d);
                o_crc_valid <= 1'b1;
            end
        end
    end
`else
    assign o_frame_crc = 8'h00;
    assign o_crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: drives whole 800x525 frames with random pixels and
// scoreboards every expected write (address, data, 2-clk latency).
module tb_vga_capture;
    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        i_h_sync = 1'b1, i_v_sync = 1'b1, i_r = 1'b0, i_g = 1'b0, i_b = 1'b0;
    logic        o_wr_en, o_locked, o_frame_start, o_frame_done, o_sync_err, o_crc_valid;
    logic [18:0] o_wr_addr;
    logic [2:0]  o_wr_data;
    logic [7:0]  o_frame_crc;

    vga_capture dut (
        .clk(clk), .reset_(reset_), .i_h_sync(i_h_sync), .i_v_sync(i_v_sync),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_locked(o_locked), .o_frame_start(o_frame_start), .o_frame_done(o_frame_done),
        .o_sync_err(o_sync_err), .o_frame_crc(o_frame_crc), .o_crc_valid(o_crc_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] addr;
        logic [2:0]  data;
        int unsigned drv;
        int          fid;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0, errors = 0;
    int          n_wr = 0, n_exp = 0, n_done = 0, n_start = 0, n_err = 0;
    int          frame_id = 0, crc_fid = -1;
    logic [7:0]  m_crc = 8'h00;
    logic        rst_q = 1'b0;
    logic [18:0] last_addr = '0;
    logic [2:0]  last_data = '0;
    logic        crc_bad = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset_;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // CRC-8/0x07 fed one data bit at a time, MSB first
    function automatic logic [7:0] crc_bitwise(input logic [7:0] c, input logic [2:0] d);
        logic [7:0] byte_in;
        logic [7:0] s;
        logic       fb;
        byte_in = {5'b00000, d};
        s = c;
        for (int i = 7; i >= 0; i--) begin
            fb = s[7] ^ byte_in[i];
            s  = {s[6:0], 1'b0};
            if (fb) s = s ^ 8'h07;
        end
        return s;
    endfunction

    // Monitor: pops the scoreboard on every write, checks hold and pulses
    always @(negedge clk) begin
        exp_t e;
        if (o_sync_err === 1'b1) n_err++;
        if (o_frame_start === 1'b1) n_start++;
        if (!rst_q) begin
            last_addr = '0;
            last_data = '0;
        end else if (o_wr_en === 1'b1) begin
            n_wr++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%h data=%b want no write", o_wr_addr, o_wr_data);
            end else begin
                e = q.pop_front();
                if (o_wr_addr !== e.addr || o_wr_data !== e.data || (cyc - e.drv) != 2) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%b lat=%0d want addr=%h data=%b lat=2",
                             o_wr_addr, o_wr_data, cyc - e.drv, e.addr, e.data);
                end
                if (e.fid != crc_fid) begin
                    crc_fid = e.fid;
                    m_crc   = 8'h00;
                end
                m_crc = crc_bitwise(m_crc, e.data);
            end
            last_addr = o_wr_addr;
            last_data = o_wr_data;
        end else begin
            checks++;
            if (o_wr_addr !== last_addr || o_wr_data !== last_data) begin
                errors++;
                $display("FAIL hold got addr=%h data=%b want addr=%h data=%b",
                         o_wr_addr, o_wr_data, last_addr, last_data);
            end
        end
        if (o_frame_done === 1'b1) begin
            n_done++;
            checks++;
            if (o_wr_en !== 1'b1 || o_wr_addr !== {9'd479, 10'd639}) begin
                errors++;
                $display("FAIL frame_done got wr_en=%b addr=%h want wr_en=1 addr=%h",
                         o_wr_en, o_wr_addr, {9'd479, 10'd639});
            end
        end
`ifdef VGA_CAPTURE_CRC_EN
        if (o_crc_valid === 1'b1) begin
            checks++;
            if (o_frame_crc !== m_crc || o_frame_done !== 1'b1) begin
                errors++;
                $display("FAIL frame_crc got %h done=%b want %h done=1", o_frame_crc, o_frame_done, m_crc);
            end
        end
`else
        if (rst_q && (o_crc_valid !== 1'b0 || o_frame_crc !== 8'h00)) crc_bad = 1'b1;
`endif
    end

    // One frame: line l, column c; hsync low for c<96, vsync low for l<2.
    // cap_lines = leading lines expected to be captured (only visible ones are pushed).
    task automatic run_frame(input int nlines, input int short_ln, input int cap_lines,
                             input bit solid, input int rst_line, input bit exp_lock);
        logic [2:0] px;
        exp_t       e;
        int         ncol;
        frame_id++;
        for (int l = 0; l < nlines; l++) begin
            ncol = (l == short_ln) ? 799 : 800;
            for (int c = 0; c < ncol; c++) begin
                px = solid ? 3'b101 : 3'($urandom_range(0, 7));
                if (!solid && l == 35 && c == 144) px = 3'b110;
                @(negedge clk);
                if (l == 2 && c == 400) chk("locked_mid_frame", 64'(o_locked), 64'(exp_lock));
                reset_   = !(l == rst_line && c == 0);
                i_h_sync = (c >= 96);
                i_v_sync = (l >= 2);
                {i_r, i_g, i_b} = px;
                if (l < cap_lines && l >= 35 && l <= 514 && c >= 144 && c <= 783) begin
                    e.addr = {9'(l - 35), 10'(c - 144)};
                    e.data = px;
                    e.drv  = cyc + 1;
                    e.fid  = frame_id;
                    q.push_back(e);
                    n_exp++;
                end
                if (!reset_) begin
                    @(posedge clk);
                    #1;
                    chk("outputs_after_reset",
                        64'({o_wr_en, o_wr_addr, o_wr_data, o_locked, o_frame_start,
                             o_frame_done, o_sync_err, o_frame_crc, o_crc_valid}), 64'd0);
                end
            end
        end
    endtask

    initial begin
        reset_ = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        chk("reset_state",
            64'({o_wr_en, o_wr_addr, o_wr_data, o_locked, o_frame_start,
                 o_frame_done, o_sync_err, o_frame_crc, o_crc_valid}), 64'd0);
        @(negedge clk);
        reset_ = 1'b1;
        repeat (10) @(negedge clk);

        run_frame(525, -1, 0,   1'b0, -1, 1'b0);  // first vsync edge: SYNCED only
        run_frame(525, -1, 525, 1'b1, -1, 1'b1);  // locked at second edge, solid 101
        chk("frame1_write_count", 64'(n_wr), 64'd307200);
        chk("frame1_done_count",  64'(n_done), 64'd1);

        run_frame(110, 100, 101, 1'b0, -1, 1'b1); // line 100 is 799 clocks long
        chk("short_line_err_count", 64'(n_err), 64'd1);
        chk("short_line_unlocked",  64'(o_locked), 64'd0);
        run_frame(525, -1, 0,   1'b0, -1, 1'b0);  // SYNCED again
        run_frame(524, -1, 524, 1'b0, -1, 1'b1);  // relocked; frame only 524 lines
        run_frame(525, -1, 0,   1'b0, -1, 1'b0);  // error at its vsync edge -> SYNCED
        chk("short_frame_err_count", 64'(n_err), 64'd2);
        run_frame(205, -1, 200, 1'b0, 200, 1'b1); // relocked; reset at line 200
        run_frame(525, -1, 0,   1'b0, -1, 1'b0);  // first edge after reset: SYNCED
        run_frame(40,  -1, 40,  1'b0, -1, 1'b1);  // second edge: LOCKED again

        repeat (20) begin
            @(negedge clk);
            i_h_sync = 1'b1;
            i_v_sync = 1'b1;
        end
        chk("scoreboard_empty",  64'(q.size()), 64'd0);
        chk("total_writes",      64'(n_wr), 64'(n_exp));
        chk("frame_done_count",  64'(n_done), 64'd2);
        chk("frame_start_count", 64'(n_start), 64'd5);
        chk("sync_err_count",    64'(n_err), 64'd2);
`ifndef VGA_CAPTURE_CRC_EN
        chk("crc_outputs_idle",  64'(crc_bad), 64'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameters: none; 640x480 timing is fixed (H total 800, sync 96, back porch 48; V total 525, sync 2, back porch 33).
REQ-002 SHALL have port clk, input, 1: pixel clock, one pixel per rising edge.
REQ-003 SHALL have port reset_, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port i_h_sync, input, 1: horizontal sync, active-low.
REQ-005 SHALL have port i_v_sync, input, 1: vertical sync, active-low.
REQ-006 SHALL have port i_r, i_g, i_b, input, 1 each: pixel colour.
REQ-007 SHALL have port o_wr_en, output, 1: captured-pixel write strobe.
REQ-008 SHALL have port o_wr_addr, output, 19: {line[8:0], pixel[9:0]}.
REQ-009 SHALL have port o_wr_data, output, 3: {r,g,b}.
REQ-010 SHALL have port o_locked, output, 1: timing lock status.
REQ-011 SHALL have port o_frame_start, output, 1: one-cycle pulse at vsync edge while locked.
REQ-012 SHALL have port o_frame_done, output, 1: one-cycle pulse coincident with write of line 479, pixel 639.
REQ-013 SHALL have port o_sync_err, output, 1: one-cycle pulse on timing violation.
REQ-014 SHALL have port o_frame_crc, output, 8, and o_crc_valid, output, 1 (see Configuration).

Function
REQ-015 SHALL register i_h_sync, i_v_sync, i_r, i_g, i_b through one input stage; a falling edge is previous-registered=1 and current-registered=0.
REQ-016 SHALL keep h_cnt (10 bits, saturating at 1023): 0 on the cycle of an hsync falling edge, else +1.
REQ-017 SHALL keep v_cnt (10 bits, saturating at 1023): 0 on a vsync falling edge, else +1 on each hsync falling edge; a simultaneous vsync and hsync edge counts as vsync only.
REQ-018 SHALL implement states SEARCH, SYNCED, LOCKED; o_locked=1 only in LOCKED.
REQ-019 SEARCH -> SYNCED on a vsync falling edge.
REQ-020 SYNCED -> LOCKED on the next vsync falling edge if v_cnt==524 and no line error occurred in the frame.
REQ-021 Line error: an hsync falling edge with h_cnt!=799 (except the first edge after entering SYNCED), or h_cnt saturating.
REQ-022 Frame error: a vsync falling edge with v_cnt!=524 in SYNCED or LOCKED, or v_cnt saturating.
REQ-023 Any line or frame error in SYNCED or LOCKED SHALL pulse o_sync_err for one cycle and go to SEARCH; if the error edge is a vsync edge, the next state is SYNCED.
REQ-024 In LOCKED, the pixel at h_cnt 144..783 and v_cnt 35..514 SHALL be written with pixel=h_cnt-144 and line=v_cnt-35.
REQ-025 Latency: o_wr_en/o_wr_addr/o_wr_data SHALL be registered and appear exactly 2 clk after the pixel is present on i_r/i_g/i_b.
REQ-026 o_wr_addr and o_wr_data SHALL hold their last values when o_wr_en=0.
REQ-027 No writes SHALL occur in SEARCH or SYNCED; a transition out of LOCKED SHALL stop writes on the following cycle.

Reset
REQ-028 While reset_=0 at a clk edge: state=SEARCH, h_cnt=v_cnt=0, edge history=1 (idle), and all outputs 0.
REQ-029 Reset asserted mid-frame SHALL abort capture immediately; relock SHALL require a full SEARCH->SYNCED->LOCKED sequence.

Configuration
REQ-030 Macro VGA_CAPTURE_CRC_EN defined: CRC-8 (poly 0x07, init 0x00, MSB-first) over byte {5'b0,r,g,b} of each written pixel; cleared at each vsync edge; result latched to o_frame_crc with a one-cycle o_crc_valid pulse coincident with o_frame_done.
REQ-031 Macro undefined: o_frame_crc=8'h00 and o_crc_valid=0 permanently; no CRC logic.

Verification
REQ-032 Reset, then 3 ideal frames of solid 3'b101 -> o_locked rises at the second vsync edge; frame 2 writes 307200 pixels, all data 3'b101, addresses 0x00000..{479,639}; o_frame_done pulses once per frame.
REQ-033 Locked; a single line 799 clocks long -> o_sync_err pulses once, o_locked=0, writes stop; relock after 2 good vsync edges.
REQ-034 Locked; a frame of 524 lines -> o_sync_err at that vsync edge, state SYNCED, LOCKED at the next good vsync edge.
REQ-035 Pixel 3'b110 at h_cnt=144, v_cnt=35 -> o_wr_en with addr 0 and data 3'b110 exactly 2 clk later; pixels at h_cnt 143 and 784 are never written.
REQ-036 reset_=0 for 1 clk mid-frame at line 200 -> all outputs 0 next cycle; no writes until the second subsequent vsync edge.
REQ-037 With VGA_CAPTURE_CRC_EN defined: all-zero frame -> o_frame_crc=8'h00; repeat same frame -> identical CRC; undefined -> o_crc_valid never asserts.
